// File: rtl/lynxTypes.sv
// Shared types and defaults for the per-lane AXI4-Stream packet decoupler.
// Optional feature macro: DECOUPLE_FLUSH_EN (flush isolated lanes instead of backpressuring).
package lynxTypes;

  // Default stream width and number of independent lanes.
  localparam int AXI_DATA_BITS = 512;
  localparam int N_REGIONS     = 2;

  // Per-lane isolation state.
  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    DRAIN     = 2'd1,
    DECOUPLED = 2'd2,
    RESYNC    = 2'd3
  } lane_state_t;

  // True in the states where the lane forwards traffic downstream.
  function automatic logic lane_passes(input lane_state_t st);
    return (st == ACTIVE) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/AXI4S.sv
// AXI4-Stream bundle with master and slave views.
interface AXI4S #(
  parameter int AXI4S_DATA_BITS = lynxTypes::AXI_DATA_BITS
) ();

  logic [AXI4S_DATA_BITS-1:0]   tdata;
  logic [AXI4S_DATA_BITS/8-1:0] tkeep;
  logic                         tlast;
  logic                         tvalid;
  logic                         tready;

  modport m (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport s (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axis_pkt_decoupler_lane.sv
// Handshake gating and packet-boundary isolation FSM for one stream lane.
// Data, keep and last bypass this block; only valid/ready are gated here.
// Optional feature macro: DECOUPLE_FLUSH_EN.
module axis_pkt_decoupler_lane
  import lynxTypes::*;
(
  input  logic aclk,
  input  logic areset,
  input  logic decouple_req,
  output logic decouple_ack,
  input  logic s_tvalid,
  input  logic s_tlast,
  output logic s_tready,
  output logic m_tvalid,
  input  logic m_tready
);

  lane_state_t state_q, state_d;
  logic        in_pkt_q, in_pkt_d;
  logic        ack_q, ack_d;
  logic        pass_en;
  logic        beat_acc;

  // Gate valid/ready from the registered state only, so a request never cuts a beat mid-cycle.
  always_comb begin
    pass_en  = lane_passes(state_q);
    m_tvalid = pass_en ? s_tvalid : 1'b0;
`ifdef DECOUPLE_FLUSH_EN
    s_tready = pass_en ? m_tready : 1'b1;
`else
    s_tready = pass_en ? m_tready : 1'b0;
`endif
    beat_acc = s_tvalid & s_tready;
  end

  // Track whether the upstream source is mid-packet, including beats flushed while isolated.
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (beat_acc) begin
      in_pkt_d = ~s_tlast;
    end
  end

  // Next-state logic: isolate and rejoin only at packet boundaries.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACTIVE: begin
        if (decouple_req) begin
          state_d = in_pkt_d ? DRAIN : DECOUPLED;
        end
      end
      DRAIN: begin
        if (beat_acc && s_tlast) begin
          state_d = DECOUPLED;
        end else if (!decouple_req) begin
          state_d = ACTIVE;
        end
      end
      DECOUPLED: begin
        if (!decouple_req) begin
`ifdef DECOUPLE_FLUSH_EN
          state_d = in_pkt_d ? RESYNC : ACTIVE;
`else
          state_d = ACTIVE;
`endif
        end
      end
      RESYNC: begin
`ifdef DECOUPLE_FLUSH_EN
        if (beat_acc && s_tlast) begin
          state_d = ACTIVE;
        end
`else
        state_d = ACTIVE;
`endif
      end
      default: state_d = ACTIVE;
    endcase
    ack_d = (state_d == DECOUPLED);
  end

  // State, packet tracker and acknowledge registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ACTIVE;
      in_pkt_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
      ack_q    <= ack_d;
    end
  end

  assign decouple_ack = ack_q;

endmodule

// File: rtl/axis_pkt_decoupler.sv
// Multi-lane AXI4-Stream decoupler: each lane can be isolated at a packet boundary on request.
// Payload (tdata/tkeep/tlast) passes straight through; only the handshake is gated per lane.
// Optional feature macro: DECOUPLE_FLUSH_EN (isolated lanes accept and drop input beats).
module axis_pkt_decoupler
  import lynxTypes::*;
#(
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int N_ID      = N_REGIONS
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [N_ID-1:0] decouple_req,
  output logic [N_ID-1:0] decouple_ack,
  AXI4S.s                 s_axis [N_ID],
  AXI4S.m                 m_axis [N_ID]
);

  localparam int KEEP_BITS = DATA_BITS / 8;

  for (genvar i = 0; i < N_ID; i++) begin : g_lane
    // Lane-local payload views sized by the top parameters, so a width mismatch shows up here.
    logic [DATA_BITS-1:0] lane_tdata;
    logic [KEEP_BITS-1:0] lane_tkeep;

    assign lane_tdata       = s_axis[i].tdata;
    assign lane_tkeep       = s_axis[i].tkeep;
    assign m_axis[i].tdata  = lane_tdata;
    assign m_axis[i].tkeep  = lane_tkeep;
    assign m_axis[i].tlast  = s_axis[i].tlast;

    axis_pkt_decoupler_lane u_lane (
      .aclk         (aclk),
      .areset       (areset),
      .decouple_req (decouple_req[i]),
      .decouple_ack (decouple_ack[i]),
      .s_tvalid     (s_axis[i].tvalid),
      .s_tlast      (s_axis[i].tlast),
      .s_tready     (s_axis[i].tready),
      .m_tvalid     (m_axis[i].tvalid),
      .m_tready     (m_axis[i].tready)
    );
  end

endmodule

// File: tb/tb_axis_pkt_decoupler.sv
// Directed self-checking bench for axis_pkt_decoupler with two 32-bit lanes.
module tb_axis_pkt_decoupler;

  localparam int DW = 32;
  localparam int NL = 2;

`ifdef DECOUPLE_FLUSH_EN
  localparam logic EXP_ISO_READY = 1'b1;
`else
  localparam logic EXP_ISO_READY = 1'b0;
`endif

  logic          aclk;
  logic          areset;
  logic [NL-1:0] decouple_req;
  logic [NL-1:0] decouple_ack;

  logic [NL-1:0] s_tvalid, s_tlast, m_tready;
  logic [NL-1:0] s_tready, m_tvalid, m_tlast;
  logic [DW-1:0]   s_tdata [NL];
  logic [DW-1:0]   m_tdata [NL];
  logic [DW/8-1:0] s_tkeep [NL];
  logic [DW/8-1:0] m_tkeep [NL];

  int n_checks = 0;
  int n_pass   = 0;

  AXI4S #(.AXI4S_DATA_BITS(DW)) s_if [NL] ();
  AXI4S #(.AXI4S_DATA_BITS(DW)) m_if [NL] ();

  for (genvar g = 0; g < NL; g++) begin : g_bind
    assign s_if[g].tdata  = s_tdata[g];
    assign s_if[g].tkeep  = s_tkeep[g];
    assign s_if[g].tlast  = s_tlast[g];
    assign s_if[g].tvalid = s_tvalid[g];
    assign s_tready[g]    = s_if[g].tready;
    assign m_if[g].tready = m_tready[g];
    assign m_tvalid[g]    = m_if[g].tvalid;
    assign m_tlast[g]     = m_if[g].tlast;
    assign m_tdata[g]     = m_if[g].tdata;
    assign m_tkeep[g]     = m_if[g].tkeep;
  end

  axis_pkt_decoupler #(.DATA_BITS(DW), .N_ID(NL)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .decouple_req (decouple_req),
    .decouple_ack (decouple_ack),
    .s_axis       (s_if),
    .m_axis       (m_if)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Move to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic quiet_inputs();
    s_tvalid     = '0;
    s_tlast      = '0;
    m_tready     = '1;
    decouple_req = '0;
  endtask

  task automatic test_reset();
    areset       = 1'b1;
    decouple_req = '0;
    s_tvalid     = '0;
    s_tlast      = '0;
    m_tready     = '0;
    s_tdata[0]   = '0;
    s_tdata[1]   = '0;
    s_tkeep[0]   = '0;
    s_tkeep[1]   = '0;
    repeat (3) @(posedge aclk);
    #1;
    s_tvalid   = 2'b11;
    s_tlast    = 2'b11;
    m_tready   = 2'b11;
    s_tdata[0] = 32'hA5A5_0001;
    s_tdata[1] = 32'h5A5A_0002;
    s_tkeep[0] = 4'h3;
    s_tkeep[1] = 4'hF;
    settle();
    n_checks++;
    if (decouple_ack !== 2'b00) $display("[TB] FAIL reset_ack: got %b expected 00", decouple_ack);
    else n_pass++;
    n_checks++;
    if (m_tvalid !== 2'b11) $display("[TB] FAIL reset_m_tvalid: got %b expected 11", m_tvalid);
    else n_pass++;
    n_checks++;
    if (s_tready !== 2'b11) $display("[TB] FAIL reset_s_tready: got %b expected 11", s_tready);
    else n_pass++;
    n_checks++;
    if (m_tdata[0] !== 32'hA5A5_0001) $display("[TB] FAIL reset_tdata0: got %h expected a5a50001", m_tdata[0]);
    else n_pass++;
    n_checks++;
    if (m_tkeep[0] !== 4'h3) $display("[TB] FAIL reset_tkeep0: got %h expected 3", m_tkeep[0]);
    else n_pass++;
    n_checks++;
    if (m_tdata[1] !== 32'h5A5A_0002) $display("[TB] FAIL reset_tdata1: got %h expected 5a5a0002", m_tdata[1]);
    else n_pass++;
    areset = 1'b0;
    step();
    s_tvalid = '0;
    settle();
    n_checks++;
    if (m_tvalid !== 2'b00) $display("[TB] FAIL post_reset_tvalid: got %b expected 00", m_tvalid);
    else n_pass++;
    n_checks++;
    if (decouple_ack !== 2'b00) $display("[TB] FAIL post_reset_ack: got %b expected 00", decouple_ack);
    else n_pass++;
  endtask

  task automatic test_idle_decouple();
    quiet_inputs();
    step();
    decouple_req[0] = 1'b1;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0) $display("[TB] FAIL idle_ack_before: got %b expected 0", decouple_ack[0]);
    else n_pass++;
    step();
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b1) $display("[TB] FAIL idle_ack_rise: got %b expected 1", decouple_ack[0]);
    else n_pass++;
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b1;
    s_tdata[0]  = 32'h0000_0050;
    settle();
    n_checks++;
    if (s_tready[0] !== EXP_ISO_READY) $display("[TB] FAIL idle_iso_ready: got %b expected %b", s_tready[0], EXP_ISO_READY);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (m_tvalid[0] !== 1'b0) $display("[TB] FAIL idle_iso_tvalid[%0d]: got %b expected 0", i, m_tvalid[0]);
      else n_pass++;
      step();
      settle();
    end
    n_checks++;
    if (decouple_ack[0] !== 1'b1) $display("[TB] FAIL idle_ack_hold: got %b expected 1", decouple_ack[0]);
    else n_pass++;
    s_tvalid[0]     = 1'b0;
    decouple_req[0] = 1'b0;
    step();
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0) $display("[TB] FAIL idle_ack_fall: got %b expected 0", decouple_ack[0]);
    else n_pass++;
    s_tvalid[0] = 1'b1;
    settle();
    n_checks++;
    if (m_tvalid[0] !== 1'b1) $display("[TB] FAIL idle_resume_tvalid: got %b expected 1", m_tvalid[0]);
    else n_pass++;
    step();
    s_tvalid[0] = 1'b0;
  endtask

  task automatic test_drain_packet();
    quiet_inputs();
    step();
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b0;
    s_tdata[0]  = 32'd100;
    settle();
    n_checks++;
    if (m_tdata[0] !== 32'd100 || m_tvalid[0] !== 1'b1) $display("[TB] FAIL drain_beat1: got v=%b d=%0d expected v=1 d=100", m_tvalid[0], m_tdata[0]);
    else n_pass++;
    step();
    s_tdata[0] = 32'd101;
    step();
    s_tdata[0]      = 32'd102;
    decouple_req[0] = 1'b1;
    settle();
    n_checks++;
    if (m_tdata[0] !== 32'd102 || m_tvalid[0] !== 1'b1) $display("[TB] FAIL drain_beat3: got v=%b d=%0d expected v=1 d=102", m_tvalid[0], m_tdata[0]);
    else n_pass++;
    step();
    s_tdata[0] = 32'd103;
    s_tlast[0] = 1'b1;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0) $display("[TB] FAIL drain_ack_early: got %b expected 0", decouple_ack[0]);
    else n_pass++;
    n_checks++;
    if (m_tvalid[0] !== 1'b1 || m_tlast[0] !== 1'b1 || m_tdata[0] !== 32'd103) $display("[TB] FAIL drain_beat4: got v=%b l=%b d=%0d expected v=1 l=1 d=103", m_tvalid[0], m_tlast[0], m_tdata[0]);
    else n_pass++;
    step();
    s_tdata[0] = 32'd200;
    s_tlast[0] = 1'b0;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b1) $display("[TB] FAIL drain_ack_after_last: got %b expected 1", decouple_ack[0]);
    else n_pass++;
    n_checks++;
    if (m_tvalid[0] !== 1'b0) $display("[TB] FAIL drain_next_blocked: got %b expected 0", m_tvalid[0]);
    else n_pass++;
    n_checks++;
    if (s_tready[0] !== EXP_ISO_READY) $display("[TB] FAIL drain_iso_ready: got %b expected %b", s_tready[0], EXP_ISO_READY);
    else n_pass++;
    s_tvalid[0]     = 1'b0;
    decouple_req[0] = 1'b0;
    step();
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0) $display("[TB] FAIL drain_release: got %b expected 0", decouple_ack[0]);
    else n_pass++;
  endtask

  task automatic test_drain_stall();
    quiet_inputs();
    step();
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b0;
    s_tdata[0]  = 32'd300;
    step();
    decouple_req[0] = 1'b1;
    m_tready[0]     = 1'b0;
    s_tdata[0]      = 32'd301;
    s_tlast[0]      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      settle();
      n_checks++;
      if (s_tready[0] !== 1'b0 || decouple_ack[0] !== 1'b0) $display("[TB] FAIL stall_cycle[%0d]: got ready=%b ack=%b expected ready=0 ack=0", i, s_tready[0], decouple_ack[0]);
      else n_pass++;
    end
    m_tready[0] = 1'b1;
    settle();
    n_checks++;
    if (s_tready[0] !== 1'b1 || m_tlast[0] !== 1'b1) $display("[TB] FAIL stall_release: got ready=%b last=%b expected 1 1", s_tready[0], m_tlast[0]);
    else n_pass++;
    step();
    s_tvalid[0] = 1'b0;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b1) $display("[TB] FAIL stall_ack: got %b expected 1", decouple_ack[0]);
    else n_pass++;
    decouple_req[0] = 1'b0;
    step();
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0) $display("[TB] FAIL stall_ack_fall: got %b expected 0", decouple_ack[0]);
    else n_pass++;
  endtask

  task automatic test_drain_cancel();
    quiet_inputs();
    step();
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b0;
    s_tdata[0]  = 32'd400;
    step();
    s_tvalid[0]     = 1'b0;
    decouple_req[0] = 1'b1;
    step();
    decouple_req[0] = 1'b0;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0) $display("[TB] FAIL cancel_in_drain: got %b expected 0", decouple_ack[0]);
    else n_pass++;
    step();
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b1;
    s_tdata[0]  = 32'd401;
    settle();
    n_checks++;
    if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 32'd401) $display("[TB] FAIL cancel_tail: got v=%b d=%0d expected v=1 d=401", m_tvalid[0], m_tdata[0]);
    else n_pass++;
    step();
    s_tvalid[0] = 1'b0;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0) $display("[TB] FAIL cancel_no_ack: got %b expected 0", decouple_ack[0]);
    else n_pass++;
  endtask

  task automatic test_tlast_priority();
    quiet_inputs();
    step();
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b0;
    s_tdata[0]  = 32'd500;
    step();
    s_tvalid[0]     = 1'b0;
    decouple_req[0] = 1'b1;
    step();
    decouple_req[0] = 1'b0;
    s_tvalid[0]     = 1'b1;
    s_tlast[0]      = 1'b1;
    s_tdata[0]      = 32'd501;
    settle();
    n_checks++;
    if (m_tvalid[0] !== 1'b1 || m_tlast[0] !== 1'b1) $display("[TB] FAIL prio_tail: got v=%b l=%b expected 1 1", m_tvalid[0], m_tlast[0]);
    else n_pass++;
    step();
    s_tvalid[0] = 1'b0;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b1) $display("[TB] FAIL prio_ack: got %b expected 1", decouple_ack[0]);
    else n_pass++;
    step();
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0) $display("[TB] FAIL prio_ack_fall: got %b expected 0", decouple_ack[0]);
    else n_pass++;
  endtask

`ifdef DECOUPLE_FLUSH_EN
  task automatic test_flush_resync();
    quiet_inputs();
    step();
    decouple_req[0] = 1'b1;
    step();
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b0;
    s_tdata[0]  = 32'd700;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b1 || s_tready[0] !== 1'b1 || m_tvalid[0] !== 1'b0) $display("[TB] FAIL flush_iso: got ack=%b ready=%b v=%b expected 1 1 0", decouple_ack[0], s_tready[0], m_tvalid[0]);
    else n_pass++;
    step();
    s_tdata[0] = 32'd701;
    step();
    s_tvalid[0]     = 1'b0;
    decouple_req[0] = 1'b0;
    step();
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b1;
    s_tdata[0]  = 32'd702;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0 || m_tvalid[0] !== 1'b0 || s_tready[0] !== 1'b1) $display("[TB] FAIL flush_resync: got ack=%b v=%b ready=%b expected 0 0 1", decouple_ack[0], m_tvalid[0], s_tready[0]);
    else n_pass++;
    step();
    s_tlast[0] = 1'b0;
    s_tdata[0] = 32'd800;
    settle();
    n_checks++;
    if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 32'd800) $display("[TB] FAIL flush_next_head: got v=%b d=%0d expected v=1 d=800", m_tvalid[0], m_tdata[0]);
    else n_pass++;
    step();
    s_tlast[0] = 1'b1;
    s_tdata[0] = 32'd801;
    settle();
    n_checks++;
    if (m_tvalid[0] !== 1'b1 || m_tlast[0] !== 1'b1 || m_tdata[0] !== 32'd801) $display("[TB] FAIL flush_next_tail: got v=%b l=%b d=%0d expected 1 1 801", m_tvalid[0], m_tlast[0], m_tdata[0]);
    else n_pass++;
    step();
    s_tvalid[0] = 1'b0;
  endtask
`endif

  task automatic test_lane_independence();
    logic [DW-1:0] exp_data;
    logic          exp_last;
    quiet_inputs();
    step();
    decouple_req[0] = 1'b1;
    step();
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      exp_data    = 32'd1000 + DW'(i);
      exp_last    = ((i % 4) == 3);
      s_tdata[1]  = exp_data;
      s_tlast[1]  = exp_last;
      s_tvalid[1] = 1'b1;
      settle();
      n_checks++;
      if (s_tready[1] !== 1'b1 || m_tvalid[1] !== 1'b1 || m_tlast[1] !== exp_last || m_tdata[1] !== exp_data)
        $display("[TB] FAIL lane1_beat[%0d]: got r=%b v=%b l=%b d=%0d expected r=1 v=1 l=%b d=%0d", i, s_tready[1], m_tvalid[1], m_tlast[1], m_tdata[1], exp_last, exp_data);
      else n_pass++;
    end
    n_checks++;
    if (decouple_ack !== 2'b01 || m_tvalid[0] !== 1'b0) $display("[TB] FAIL lane0_isolated: got ack=%b v0=%b expected ack=01 v0=0", decouple_ack, m_tvalid[0]);
    else n_pass++;
    step();
    s_tvalid        = '0;
    decouple_req[0] = 1'b0;
    step();
    settle();
    n_checks++;
    if (decouple_ack !== 2'b00) $display("[TB] FAIL lane0_release: got %b expected 00", decouple_ack);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    quiet_inputs();
    step();
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b0;
    s_tdata[0]  = 32'd600;
    step();
    decouple_req[0] = 1'b1;
    m_tready[0]     = 1'b0;
    s_tlast[0]      = 1'b1;
    s_tdata[0]      = 32'd601;
    step();
    settle();
    n_checks++;
    if (s_tready[0] !== 1'b0 || decouple_ack[0] !== 1'b0) $display("[TB] FAIL rst_drain_setup: got ready=%b ack=%b expected 0 0", s_tready[0], decouple_ack[0]);
    else n_pass++;
    areset = 1'b1;
    step();
    areset          = 1'b0;
    decouple_req[0] = 1'b0;
    m_tready[0]     = 1'b1;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0 || m_tvalid[0] !== 1'b1 || s_tready[0] !== 1'b1) $display("[TB] FAIL rst_drain_resume: got ack=%b v=%b ready=%b expected 0 1 1", decouple_ack[0], m_tvalid[0], s_tready[0]);
    else n_pass++;
    step();
    s_tvalid[0] = 1'b0;
    settle();
    n_checks++;
    if (decouple_ack[0] !== 1'b0) $display("[TB] FAIL rst_drain_active: got %b expected 0", decouple_ack[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_decouple();
    test_drain_packet();
    test_drain_stall();
    test_drain_cancel();
    test_tlast_priority();
`ifdef DECOUPLE_FLUSH_EN
    test_flush_resync();
`endif
    test_lane_independence();
    test_reset_mid_drain();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_pkt_decoupler.md
AXIS_PKT_DECOUPLER -- requirements
Module: axis_pkt_decoupler

Interface
REQ-001 Parameter DATA_BITS, default AXI_DATA_BITS, AXIS data width in bits.
REQ-002 Parameter N_ID, default N_REGIONS, number of independent stream lanes.
REQ-003 aclk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 areset  input  1  reset, synchronous and active-high.
REQ-005 decouple_req  input  N_ID  per-lane request to isolate the lane at a packet boundary.
REQ-006 decouple_ack  output  N_ID  per-lane registered flag: lane is isolated.
REQ-007 s_axis  AXI4S.s  [N_ID]  upstream streams (tdata DATA_BITS, tkeep DATA_BITS/8, tlast, tvalid, tready).
REQ-008 m_axis  AXI4S.m  [N_ID]  downstream streams, same widths.

Function
REQ-009 Lanes SHALL be fully independent; every rule below applies per lane.
REQ-010 tdata, tkeep and tlast SHALL pass from s to m combinationally with zero latency in all states.
REQ-011 Accepted beat = s tvalid & s tready in the same cycle.
REQ-012 Flag in_pkt SHALL set on an accepted beat with tlast=0 and clear on an accepted beat with tlast=1.
REQ-013 The FSM SHALL have states ACTIVE, DRAIN, DECOUPLED and RESYNC; gating depends only on the registered state, never combinationally on decouple_req.
REQ-014 ACTIVE and DRAIN: m tvalid = s tvalid; s tready = m tready.
REQ-015 DECOUPLED and RESYNC: m tvalid = 0; s tready per REQ-024/REQ-025.
REQ-016 ACTIVE, decouple_req=1 at the edge: next state DECOUPLED if in_pkt after this cycle's beat is 0, else DRAIN.
REQ-017 DRAIN: an accepted beat with tlast=1 SHALL move the lane to DECOUPLED; decouple_req=0 with no such beat SHALL return the lane to ACTIVE.
REQ-018 DRAIN: if decouple_req=0 and a tlast beat is accepted in the same cycle, tlast SHALL take priority; next state DECOUPLED.
REQ-019 DECOUPLED with decouple_req=0: next state RESYNC if input-side in_pkt=1, else ACTIVE.
REQ-020 RESYNC: an accepted tlast beat SHALL move the lane to ACTIVE; decouple_req is ignored in RESYNC.
REQ-021 decouple_ack SHALL be 1 exactly while the state is DECOUPLED; it rises one cycle after the transition edge.
REQ-022 No packet SHALL ever be truncated or split at the m side by a decouple/recouple cycle.

Reset
REQ-023 With areset=1 at an edge: state ACTIVE, in_pkt 0, decouple_ack 0; m tvalid follows s tvalid from the next cycle; any in-flight packet is abandoned without tlast insertion.

Configuration
REQ-024 Macro DECOUPLE_FLUSH_EN defined: in DECOUPLED and RESYNC, s tready = 1 and accepted beats are discarded; in_pkt keeps tracking these beats.
REQ-025 DECOUPLE_FLUSH_EN undefined: in DECOUPLED, s tready = 0 (backpressure); RESYNC is unreachable, and its logic may be optimised out.

Structure
REQ-026 The lane state enum (ACTIVE, DRAIN, DECOUPLED, RESYNC) SHALL be a typedef in lynxTypes.
REQ-027 Per-lane logic SHALL live in sub-module axis_pkt_decoupler_lane, instantiated N_ID times by a generate loop.
REQ-028 DATA_BITS/N_ID SHALL be the only parameters; no per-lane parameters.

Verification
REQ-029 Idle lane, req=1 at cycle 10 -> ack=1 at cycle 11; m tvalid=0 thereafter, even with s tvalid=1.
REQ-030 4-beat packet, req asserted after beat 2 -> beats 3 and 4 pass; ack=1 the cycle after the tlast beat; the next packet is blocked.
REQ-031 DRAIN with m tready=0 for 20 cycles -> ack stays 0 and s tready=0 until tlast is accepted.
REQ-032 FLUSH_EN, decoupled, source sends 2 of 3 beats, req drops -> RESYNC; beat 3 dropped; the next packet passes intact with tlast.
REQ-033 Lane 0 decoupled while lane 1 streams 100 beats -> lane 1 sees no stall and no data loss.
REQ-034 areset pulsed mid-DRAIN -> next cycle ack=0, state ACTIVE, pass-through resumes.
